// File: rtl/branch_forward_scoreboard_if.sv
// ID-stage branch forwarding bundle: instruction fields in,
// forward selects / stall / perf count out.
interface branch_forward_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int NUM_OPS    = 2
);
  localparam int SEL_W = $clog2(DEPTH);

  logic                          pipe_en;
  logic                          id_valid;
  logic                          id_wr_en;
  logic                          id_is_load;
  logic [REG_ADDR_W-1:0]         id_rd;
  logic                          id_is_branch;
  logic [NUM_OPS-1:0]            id_op_used;
  logic [NUM_OPS*REG_ADDR_W-1:0] id_op_reg;
  logic [NUM_OPS*SEL_W-1:0]      branch_fwd_sel;
  logic                          branch_stall;
  logic [31:0]                   stall_cycles;

  modport master (
    output pipe_en, id_valid, id_wr_en, id_is_load, id_rd,
    output id_is_branch, id_op_used, id_op_reg,
    input  branch_fwd_sel, branch_stall, stall_cycles
  );

  modport slave (
    input  pipe_en, id_valid, id_wr_en, id_is_load, id_rd,
    input  id_is_branch, id_op_used, id_op_reg,
    output branch_fwd_sel, branch_stall, stall_cycles
  );
endinterface

// File: rtl/branch_forward_scoreboard.sv
// Shift-register scoreboard selecting branch forward sources in ID.
// Optional stall-cycle counter enabled by BRANCH_FWD_PERF_EN.
module branch_forward_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int NUM_OPS    = 2,
  parameter int LOAD_LAT   = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  branch_forward_scoreboard_if.slave bus
);
  localparam int SEL_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  logic                  valid_q [DEPTH];
  logic                  valid_d [DEPTH];
  logic [REG_ADDR_W-1:0] rd_q    [DEPTH];
  logic [REG_ADDR_W-1:0] rd_d    [DEPTH];
  logic [CNT_W-1:0]      cnt_q   [DEPTH];
  logic [CNT_W-1:0]      cnt_d   [DEPTH];

  logic [NUM_OPS-1:0]       op_stall;
  logic [NUM_OPS*SEL_W-1:0] fwd_sel;
  logic                     stall;
  logic                     push;

  // Per operand: youngest matching slot decides forward or stall.
  always_comb begin : sel_blk
    logic                  found;
    logic [SEL_W-1:0]      win;
    logic [CNT_W-1:0]      wcnt;
    logic [REG_ADDR_W-1:0] opr;
    logic                  chk;
    fwd_sel  = '0;
    op_stall = '0;
    found    = 1'b0;
    win      = '0;
    wcnt     = '0;
    opr      = '0;
    chk      = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) begin
      found = 1'b0;
      win   = '0;
      wcnt  = '0;
      opr   = bus.id_op_reg[i*REG_ADDR_W +: REG_ADDR_W];
      chk   = bus.id_is_branch & bus.id_valid &
              bus.id_op_used[i] & (opr != '0);
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (chk && valid_q[k] && rd_q[k] == opr) begin
          found = 1'b1;
          win   = SEL_W'(k);
          wcnt  = cnt_q[k];
        end
      end
      if (found) begin
        if (win == '0 || wcnt != '0)
          op_stall[i] = 1'b1;
        else
          fwd_sel[i*SEL_W +: SEL_W] = win;
      end
    end
  end

  assign stall = |op_stall;
  assign push  = bus.id_valid & bus.id_wr_en & ~stall &
                 (bus.id_rd != '0);

  assign bus.branch_stall   = stall;
  assign bus.branch_fwd_sel = fwd_sel;

  // Shift the scoreboard on advance, hold when frozen.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k];
      rd_d[k]    = rd_q[k];
      cnt_d[k]   = cnt_q[k];
    end
    if (bus.pipe_en) begin
      valid_d[0] = push;
      rd_d[0]    = push ? bus.id_rd : '0;
      cnt_d[0]   = !push ? '0 :
                   bus.id_is_load ? CNT_W'(LOAD_LAT) : CNT_W'(1);
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        rd_d[k]    = rd_q[k-1];
        cnt_d[k]   = (cnt_q[k-1] == '0) ? '0 : cnt_q[k-1] - 1'b1;
      end
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        rd_q[k]    <= '0;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= valid_d[k];
        rd_q[k]    <= rd_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

`ifdef BRANCH_FWD_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  // Count advancing stall cycles, saturating.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (bus.pipe_en && stall && stall_cycles_q != 32'hFFFF_FFFF)
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign bus.stall_cycles = stall_cycles_q;
`else
  assign bus.stall_cycles = '0;
`endif
endmodule
